// File: rtl/input_cond_pkg.sv
// Shared constants and sizing/parameter-check helpers for the input_cond block.
package input_cond_pkg;

  localparam int SYNC_STAGES_MIN = 2;

  // Counter width for values 0..n-1, never below one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((r < 31) && ((32'sd1 << r) < n)) begin
      r = r + 1;
    end
    if (r < 1) begin
      r = 1;
    end
    return r;
  endfunction

  function automatic bit params_ok(input int width, input int sync_stages, input int db_cycles);
    return (width >= 1) && (sync_stages >= SYNC_STAGES_MIN) && (db_cycles >= 1);
  endfunction

endpackage

// File: rtl/input_cond_if.sv
// Pin-side bundle of input_cond: raw inputs in, conditioned level/pulses/valid out.
interface input_cond_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] level;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             valid;

  modport master (output in, input level, rise, fall, valid);
  modport slave  (input in, output level, rise, fall, valid);
endinterface

// File: rtl/input_cond_chan.sv
// One conditioned channel: synchroniser, optional debounce counter, level and edge pulses.
// Debounce is built only when INPUT_COND_DEBOUNCE_EN is defined.
module input_cond_chan
  import input_cond_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
`ifdef INPUT_COND_DEBOUNCE_EN
  parameter int   DB_CYCLES   = 16,
`endif
  parameter logic RESET_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic arm_i,
  input  logic in_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   s_s;

`ifdef INPUT_COND_DEBOUNCE_EN
  localparam int CNT_W = clog2(DB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

  assign s_s = sync_q[SYNC_STAGES-1];

  // Until armed, level tracks the synchroniser so it starts from the real pin state.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], in_i};
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
`ifdef INPUT_COND_DEBOUNCE_EN
    cnt_d   = {CNT_W{1'b0}};
`endif
    if (!arm_i) begin
      level_d = s_s;
    end else begin
`ifdef INPUT_COND_DEBOUNCE_EN
      if (s_s == level_q) begin
        cnt_d = {CNT_W{1'b0}};
      end else if (cnt_q == CNT_LAST) begin
        level_d = s_s;
        rise_d  = s_s;
        fall_d  = ~s_s;
      end else begin
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
`else
      level_d = s_s;
      rise_d  = s_s & ~level_q;
      fall_d  = ~s_s & level_q;
`endif
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
      level_q <= RESET_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
`ifdef INPUT_COND_DEBOUNCE_EN
      cnt_q   <= {CNT_W{1'b0}};
`endif
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
`ifdef INPUT_COND_DEBOUNCE_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

endmodule

// File: rtl/input_cond_chk.sv
// Runtime checks for input_cond: legal parameters, exclusive rise/fall, no pulses before valid.
module input_cond_chk
  import input_cond_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input logic             clk,
  input logic             reset_n,
  input logic [WIDTH-1:0] rise_i,
  input logic [WIDTH-1:0] fall_i,
  input logic             valid_i
);

  // Sampled once per cycle while out of reset.
  always @(posedge clk) begin
    if (reset_n) begin
      assert (params_ok(WIDTH, SYNC_STAGES, DB_CYCLES));
      assert ((rise_i & fall_i) == {WIDTH{1'b0}});
      assert (valid_i || ((rise_i | fall_i) == {WIDTH{1'b0}}));
    end
  end

endmodule

// File: rtl/input_cond.sv
// Multi-channel input conditioner: WIDTH independent channels sharing one init window / valid.
// Debounce filtering is enabled by defining INPUT_COND_DEBOUNCE_EN.
module input_cond
  import input_cond_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter int               SYNC_STAGES = 2,
  parameter int               DB_CYCLES   = 16,
  parameter logic [WIDTH-1:0] RESET_LEVEL = {WIDTH{1'b0}}
) (
  input logic         clk,
  input logic         reset_n,
  input_cond_if.slave bus
);

  localparam int INIT_W = clog2(SYNC_STAGES + 1);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(SYNC_STAGES);

  logic [INIT_W-1:0] init_q, init_d;
  logic              valid_q, valid_d;
  logic [WIDTH-1:0]  level_s, rise_s, fall_s;

  // Init window spans SYNC_STAGES+1 edges so the synchroniser holds real pin data before arming.
  always_comb begin
    init_d  = init_q;
    valid_d = valid_q;
    if (!valid_q) begin
      if (init_q == INIT_LAST) begin
        valid_d = 1'b1;
        init_d  = {INIT_W{1'b0}};
      end else begin
        init_d = init_q + {{(INIT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      init_d = init_q;
    end
  end

  // Init counter and sticky valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_q  <= {INIT_W{1'b0}};
      valid_q <= 1'b0;
    end else begin
      init_q  <= init_d;
      valid_q <= valid_d;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    input_cond_chan #(
      .SYNC_STAGES (SYNC_STAGES),
`ifdef INPUT_COND_DEBOUNCE_EN
      .DB_CYCLES   (DB_CYCLES),
`endif
      .RESET_LEVEL (RESET_LEVEL[i])
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .arm_i   (valid_q),
      .in_i    (bus.in[i]),
      .level_o (level_s[i]),
      .rise_o  (rise_s[i]),
      .fall_o  (fall_s[i])
    );
  end

  assign bus.level = level_s;
  assign bus.rise  = rise_s;
  assign bus.fall  = fall_s;
  assign bus.valid = valid_q;

  input_cond_chk #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES),
    .DB_CYCLES   (DB_CYCLES)
  ) u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .rise_i  (rise_s),
    .fall_i  (fall_s),
    .valid_i (valid_q)
  );

endmodule

// File: tb/tb_input_cond.sv
// Self-checking bench for input_cond: vector table, directed corner sequences, random stimulus vs reference model.
module tb_input_cond;

  localparam int W  = 4;
  localparam int S  = 2;
  localparam int DB = 4;
`ifdef INPUT_COND_DEBOUNCE_EN
  localparam int DB_EFF = DB;
`else
  localparam int DB_EFF = 1;
`endif
  localparam int LAT = S + DB_EFF;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  input_cond_if #(.WIDTH(W)) bus ();

  input_cond #(
    .WIDTH       (W),
    .SYNC_STAGES (S),
    .DB_CYCLES   (DB),
    .RESET_LEVEL (4'b0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  // Reference model: level follows s during init; afterwards changes once s has disagreed DB_EFF edges in a row.
  logic [W-1:0] m_hist [S];
  logic [W-1:0] m_level, m_rise, m_fall;
  int           m_run [W];
  int           m_edges;
  logic         m_valid;

  typedef struct {
    logic [W-1:0] in_v;
    int           hold;
    logic [W-1:0] exp_level;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int j = 0; j < S; j++) m_hist[j] = '0;
    for (int i = 0; i < W; i++) m_run[i] = 0;
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
    m_edges = 0;
    m_valid = 1'b0;
  endtask

  task automatic model_edge(input logic [W-1:0] x);
    logic [W-1:0] s;
    s = m_hist[S-1];
    m_rise = '0;
    m_fall = '0;
    if (!m_valid) begin
      m_level = s;
      for (int i = 0; i < W; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < W; i++) begin
        if (s[i] != m_level[i]) begin
          m_run[i]++;
          if (m_run[i] == DB_EFF) begin
            m_level[i] = s[i];
            if (s[i]) m_rise[i] = 1'b1;
            else      m_fall[i] = 1'b1;
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
    end
    for (int j = S - 1; j > 0; j--) m_hist[j] = m_hist[j-1];
    m_hist[0] = x;
    m_edges++;
    if (m_edges >= S + 1) m_valid = 1'b1;
  endtask

  // Called at a negedge; drives, lets one rising edge pass, compares against the model, returns at next negedge.
  task automatic tick(input logic [W-1:0] v);
    bus.in = v;
    @(posedge clk);
    model_edge(v);
    #1;
    check("tick", 32'({bus.level, bus.rise, bus.fall, bus.valid}),
                  32'({m_level, m_rise, m_fall, m_valid}));
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int rise_at, fall_at, cnt_a, cnt_b, acc;
    logic [W-1:0] v;

    tbl[0] = '{4'b0000, 8, 4'b0000};
    tbl[1] = '{4'b1111, 8, 4'b1111};
    tbl[2] = '{4'b1010, 8, 4'b1010};
    tbl[3] = '{4'b0110, 8, 4'b0110};
    tbl[4] = '{4'b1001, 8, 4'b1001};
    tbl[5] = '{4'b0011, 8, 4'b0011};

    // Power-up reset with in=0101, then the init window.
    bus.in  = 4'b0101;
    reset_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_vals", 32'({bus.level, bus.rise, bus.fall, bus.valid}), 32'd0);
    reset_n = 1'b1;
    acc = 0;
    for (int k = 1; k <= 3; k++) begin
      tick(4'b0101);
      check("init_valid", 32'(bus.valid), 32'(k == 3));
      acc = acc | int'(bus.rise) | int'(bus.fall);
    end
    check("init_level", 32'(bus.level), 32'(4'b0101));
    check("init_no_pulse", 32'(acc), 32'd0);

    // Table-driven settled levels.
    for (int r = 0; r < 6; r++) begin
      for (int h = 0; h < tbl[r].hold; h++) tick(tbl[r].in_v);
      check("table_level", 32'(bus.level), 32'(tbl[r].exp_level));
    end

    // in[0] 0->1 latency and single rise pulse.
    for (int h = 0; h < 8; h++) tick(4'b0100);
    rise_at = -1; cnt_a = 0; acc = 0;
    for (int k = 1; k <= 12; k++) begin
      tick(4'b0101);
      if (bus.level[0] && rise_at < 0) rise_at = k;
      cnt_a = cnt_a + int'(bus.rise[0]);
      acc = acc | int'(bus.fall);
    end
    check("lat_edge", 32'(rise_at), 32'(LAT));
    check("lat_rise_cnt", 32'(cnt_a), 32'd1);
    check("lat_no_fall", 32'(acc), 32'd0);
    check("lat_others", 32'(bus.level[3:1]), 32'(3'b010));

`ifdef INPUT_COND_DEBOUNCE_EN
    // Three-cycle glitch on in[1] is filtered.
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      tick(4'b0111);
      acc = acc | int'(bus.level[1]) | int'(bus.rise[1]) | int'(bus.fall[1]);
    end
    for (int k = 0; k < 8; k++) begin
      tick(4'b0101);
      acc = acc | int'(bus.level[1]) | int'(bus.rise[1]) | int'(bus.fall[1]);
    end
    check("glitch3", 32'(acc), 32'd0);
`else
    // One-cycle pulse on in[0] reproduced on level[0].
    for (int k = 0; k < 6; k++) tick(4'b0100);
    rise_at = -1; cnt_a = 0;
    for (int k = 1; k <= 7; k++) begin
      tick((k == 1) ? 4'b0101 : 4'b0100);
      if (bus.level[0]) begin
        cnt_a++;
        if (rise_at < 0) rise_at = k;
      end
    end
    check("pulse1_width", 32'(cnt_a), 32'd1);
    check("pulse1_edge", 32'(rise_at), 32'(S + 1));
    for (int k = 0; k < 6; k++) tick(4'b0101);
`endif

    // Four-cycle pulse on in[1] passes: one rise, one fall, four edges apart.
    rise_at = -1; fall_at = -1; cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 16; k++) begin
      tick((k <= 4) ? 4'b0111 : 4'b0101);
      if (bus.rise[1]) begin cnt_a++; rise_at = k; end
      if (bus.fall[1]) begin cnt_b++; fall_at = k; end
    end
    check("pulse4_rise", 32'(cnt_a), 32'd1);
    check("pulse4_fall", 32'(cnt_b), 32'd1);
    check("pulse4_rise_edge", 32'(rise_at), 32'(LAT));
    check("pulse4_span", 32'(fall_at - rise_at), 32'd4);

    // Simultaneous rise on ch2 and fall on ch3.
    for (int h = 0; h < 8; h++) tick(4'b1001);
    rise_at = -1; fall_at = -1;
    for (int k = 1; k <= 10; k++) begin
      tick(4'b0101);
      if (bus.rise[2]) rise_at = k;
      if (bus.fall[3]) fall_at = k;
    end
    check("simul_rise2", 32'(rise_at), 32'(LAT));
    check("simul_fall3", 32'(fall_at), 32'(LAT));

    // Reset in the middle of a ch0 debounce count.
    for (int h = 0; h < 8; h++) tick(4'b1110);
    for (int h = 0; h < 4; h++) tick(4'b1111);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("reset_mid", 32'({bus.level, bus.rise, bus.fall, bus.valid}), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    acc = 0;
    for (int h = 0; h < 8; h++) begin
      tick(4'b1111);
      acc = acc | int'(bus.rise) | int'(bus.fall);
    end
    check("reset_mid_no_pulse", 32'(acc), 32'd0);
    check("reset_mid_level", 32'(bus.level), 32'(4'b1111));

    // Random stimulus, mostly slow changes with occasional short glitches.
    v = 4'b1111;
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < W; i++) begin
        if ($urandom_range(0, 5) == 0) v[i] = ~v[i];
      end
      tick(v);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
